// File: rtl/estagio_busca.sv
// Purpose: instruction-fetch stage; owns the PC, drives the instruction-memory address, fills the IF/ID register.
// Latency: the word read at pc appears on instrucao_id one clock later, because the memory read is combinational.
// Backpressure: stall holds the PC and IF/ID; flush or a redirect squashes IF/ID to a nop, and a redirect also overrides stall.
module estagio_busca #(
  parameter logic [31:0] PC_INICIAL   = 32'h00000000,
  parameter int unsigned LARGURA_CONT = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    desvio_tomado,
  input  logic [31:0]             alvo_desvio,
  input  logic                    salto,
  input  logic [31:0]             alvo_salto,
  input  logic [31:0]             instrucao,
  output logic [31:0]             pc,
  output logic [31:0]             instrucao_id,
  output logic [31:0]             pc_mais4_id,
  output logic                    valido_id,
  output logic [LARGURA_CONT-1:0] contador_busca
);

  logic        redirecao;
  logic [31:0] pc_mais4;
  logic [31:0] pc_prox;
  logic        carrega_id;

  assign redirecao  = salto | desvio_tomado;
  // Addition is 32 bits wide, so 32'hFFFFFFFC wraps to 0.
  assign pc_mais4   = pc + 32'd4;
  assign carrega_id = ~(flush | redirecao) & ~stall;

  // Next-PC selection: jump beats branch, and any redirect beats stall.
  // Target low bits are forced to zero; misaligned targets are not trapped.
  always_comb begin
    pc_prox = pc_mais4;
    if (salto)
      pc_prox = {alvo_salto[31:2], 2'b00};
    else if (desvio_tomado)
      pc_prox = {alvo_desvio[31:2], 2'b00};
    else if (stall)
      pc_prox = pc;
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= PC_INICIAL;
    else
      pc <= pc_prox;
  end

  // IF/ID register: a squash overrides stall, stall holds, otherwise load the fetched word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrucao_id <= 32'd0;
      pc_mais4_id  <= 32'd0;
      valido_id    <= 1'b0;
    end else if (flush | redirecao) begin
      instrucao_id <= 32'd0;
      pc_mais4_id  <= 32'd0;
      valido_id    <= 1'b0;
    end else if (!stall) begin
      instrucao_id <= instrucao;
      pc_mais4_id  <= pc_mais4;
      valido_id    <= 1'b1;
    end
  end

  // Fetch counter: advances only on edges where IF/ID takes a real instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      contador_busca <= '0;
    else if (carrega_id)
      contador_busca <= contador_busca + 1'b1;
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: a combinational instruction memory model plus hand-computed expectations.
// Stimulus is driven 1 ns after each rising edge, and outputs are sampled at the same point.
// Covers reset, free-run, stall, branch, jump-over-branch, target alignment, flush, PC wrap and async reset.
module tb_estagio_busca;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        desvio_tomado;
  logic [31:0] alvo_desvio;
  logic        salto;
  logic [31:0] alvo_salto;
  logic [31:0] instrucao;
  logic [31:0] pc;
  logic [31:0] instrucao_id;
  logic [31:0] pc_mais4_id;
  logic        valido_id;
  logic [31:0] contador_busca;

  logic [31:0] mem [0:63];

  int checks;
  int failures;

  estagio_busca #(
    .PC_INICIAL  (32'h00000000),
    .LARGURA_CONT(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .desvio_tomado (desvio_tomado),
    .alvo_desvio   (alvo_desvio),
    .salto         (salto),
    .alvo_salto    (alvo_salto),
    .instrucao     (instrucao),
    .pc            (pc),
    .instrucao_id  (instrucao_id),
    .pc_mais4_id   (pc_mais4_id),
    .valido_id     (valido_id),
    .contador_busca(contador_busca)
  );

  // Combinational instruction memory, word-indexed by pc[7:2].
  assign instrucao = mem[pc[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic confere(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [31:0] e_pm4, input logic e_vld, input logic [31:0] e_cnt);
    verifica({tag, ".pc"},  pc,                      e_pc);
    verifica({tag, ".ins"}, instrucao_id,            e_ins);
    verifica({tag, ".pm4"}, pc_mais4_id,             e_pm4);
    verifica({tag, ".vld"}, {31'd0, valido_id},      {31'd0, e_vld});
    verifica({tag, ".cnt"}, contador_busca,          e_cnt);
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic limpa();
    stall         = 1'b0;
    flush         = 1'b0;
    desvio_tomado = 1'b0;
    salto         = 1'b0;
    alvo_desvio   = 32'd0;
    alvo_salto    = 32'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = 32'h20080001;
    mem[1]  = 32'h20090002;
    mem[2]  = 32'h01095020;
    mem[3]  = 32'hAC0A0000;
    mem[8]  = 32'h12345678;
    mem[16] = 32'h20100010;
    // mem[63] stays 0 so an all-zero word is fetched and must load as valid.

    reset = 1'b1;
    limpa();
    #12;
    confere("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    confere("first", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // Free run.
    ciclo(); confere("run1", 32'h4, 32'h20080001, 32'h4, 1'b1, 32'd1);
    ciclo(); confere("run2", 32'h8, 32'h20090002, 32'h8, 1'b1, 32'd2);

    // Two stall cycles while pc = 8.
    stall = 1'b1;
    ciclo(); confere("stall1", 32'h8, 32'h20090002, 32'h8, 1'b1, 32'd2);
    ciclo(); confere("stall2", 32'h8, 32'h20090002, 32'h8, 1'b1, 32'd2);
    stall = 1'b0;
    ciclo(); confere("run3", 32'hC,  32'h01095020, 32'hC,  1'b1, 32'd3);
    ciclo(); confere("run4", 32'h10, 32'hAC0A0000, 32'h10, 1'b1, 32'd4);

    // Jump back to 8, then take a branch to 0x40 while pc = 8.
    salto = 1'b1; alvo_salto = 32'h8;
    ciclo(); confere("jmp8", 32'h8, 32'h0, 32'h0, 1'b0, 32'd4);
    limpa();
    desvio_tomado = 1'b1; alvo_desvio = 32'h40;
    ciclo(); confere("br40", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
    limpa();
    ciclo(); confere("ld16", 32'h44, 32'h20100010, 32'h44, 1'b1, 32'd5);

    // A jump, a branch and a stall together: the jump wins and IF/ID is squashed.
    salto = 1'b1; alvo_salto = 32'h20;
    desvio_tomado = 1'b1; alvo_desvio = 32'h40;
    stall = 1'b1;
    ciclo(); confere("prio", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5);
    limpa();

    // Misaligned target: the low bits are dropped.
    salto = 1'b1; alvo_salto = 32'h23;
    ciclo(); confere("align", 32'h20, 32'h0, 32'h0, 1'b0, 32'd5);
    limpa();
    ciclo(); confere("ld8", 32'h24, 32'h12345678, 32'h24, 1'b1, 32'd6);

    // Flush alone squashes IF/ID but the PC keeps advancing.
    flush = 1'b1;
    ciclo(); confere("flush", 32'h28, 32'h0, 32'h0, 1'b0, 32'd6);
    limpa();

    // PC wrap: jump to FFFFFFFC, then the next PC is 0 and the all-zero word loads as valid.
    salto = 1'b1; alvo_salto = 32'hFFFFFFFC;
    ciclo(); confere("jmpmax", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 32'd6);
    limpa();
    ciclo(); confere("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 32'd7);
    ciclo(); confere("w1", 32'h4, 32'h20080001, 32'h4, 1'b1, 32'd8);
    ciclo(); confere("w2", 32'h8, 32'h20090002, 32'h8, 1'b1, 32'd9);
    ciclo(); confere("w3", 32'hC, 32'h01095020, 32'hC, 1'b1, 32'd10);

    // Asynchronous reset in mid-cycle while pc = C and valido_id = 1.
    #3;
    reset = 1'b1;
    #1;
    confere("arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    confere("arst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    ciclo(); confere("resume", 32'h4, 32'h20080001, 32'h4, 1'b1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
Instruction-fetch stage of the MIPS datapath, directly upstream of the instruction memory. It owns the PC register and drives the memory address. It also captures the returned instruction word into the IF/ID pipeline register consumed by decode. It handles stall, flush, and branch/jump redirection, and keeps a count of fetched instructions.

Parameters:
PC_INICIAL, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
LARGURA_CONT, 32, width of the fetched-instruction counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from decode; holds PC and IF/ID
flush  input  1  invalidates IF/ID contents (wrong-path squash)
desvio_tomado  input  1  conditional branch resolved as taken
alvo_desvio  input  32  branch target address
salto  input  1  jump (j/jal/jr) redirect
alvo_salto  input  32  jump target address
instrucao  input  32  word returned combinationally by instruction memory for pc
pc  output  32  current PC, drives instruction-memory address
instrucao_id  output  32  IF/ID instruction register
pc_mais4_id  output  32  IF/ID PC+4 register
valido_id  output  1  IF/ID holds a real instruction
contador_busca  output  LARGURA_CONT  number of instructions loaded into IF/ID

Behaviour:
- Reset is asynchronous, active-high, and applies immediately, including mid-operation.
  - pc = PC_INICIAL
  - instrucao_id = 0
  - pc_mais4_id = 0
  - valido_id = 0
  - contador_busca = 0
- Next-PC priority, highest first:
  - salto: pc <= {alvo_salto[31:2],2'b00}
  - desvio_tomado: pc <= {alvo_desvio[31:2],2'b00}
  - stall: pc holds
  - otherwise: pc <= pc + 4
- Redirect (salto or desvio_tomado) overrides stall.
- If salto and desvio_tomado are asserted together, salto wins.
- Target bits [1:0] are always forced to 0; no misalignment exception.
- pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- IF/ID update each rising edge, priority:
  - flush or salto or desvio_tomado: instrucao_id <= 0 (nop), pc_mais4_id <= 0, valido_id <= 0. A redirect implicitly squashes the word fetched that cycle. This case overrides stall.
  - stall: all IF/ID registers hold.
  - otherwise: instrucao_id <= instrucao, pc_mais4_id <= pc + 4, valido_id <= 1.
- Latency: the word at address P, while pc = P, appears on instrucao_id one cycle later (after the edge that advances pc). Memory read is combinational, so there are no wait states.
- contador_busca increments by 1 exactly on edges where IF/ID loads from instrucao (valido_id <= 1). It wraps at 2^LARGURA_CONT and does not change on stall, flush, or redirect.
- An all-zero instruction word (sll nop) is loaded as a valid instruction; no special-casing.
- All state is updated on the rising edge of clk only, except reset.

Test Plan:
- Reset, then free-run with memory holding 20080001, 20090002, 01095020, AC0A0000 at words 0-3:
  - pc steps 0,4,8,C,10.
  - instrucao_id follows one cycle behind (20080001 with pc_mais4_id=4, then 20090002/8, 01095020/C, AC0A0000/10).
  - valido_id=0 in the first cycle, then 1.
  - contador_busca=4 after four loads.
- Stall asserted 2 cycles while pc=8: pc stays 8; instrucao_id stays 20090002; contador_busca unchanged. On release, 01095020 is loaded.
- desvio_tomado=1, alvo_desvio=32'h40 while pc=8:
  - next pc=40.
  - IF/ID becomes instrucao_id=0, valido_id=0.
  - Next cycle loads mem[16] with pc_mais4_id=44.
- salto=1/alvo_salto=32'h20 together with desvio_tomado=1/alvo_desvio=32'h40 and stall=1: pc=20; IF/ID squashed.
- alvo_salto=32'h23: pc=20. Also force pc to FFFFFFFC via jump; next pc=0 and pc_mais4_id=0 on load.
- Assert reset asynchronously mid-cycle while pc=C and valido_id=1: all outputs go to reset values before the next clock edge. Fetch resumes at PC_INICIAL after release.
